// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port A is the core MEM stage and port B is the debug/loader port.
// At most one request is granted per cycle, and the grant is combinational.
// Read data returns to the winning port one cycle after its grant.
// Port B can lock the memory for bursts.
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DM_ADDRESS-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [2:0]            a_funct3,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [DM_ADDRESS-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  input  logic [2:0]            b_funct3,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic {ARB, LOCK_B} state_t;

  state_t state_reg, state_next;
  // last_b_reg = 1: B won the last contested cycle, so A wins the next one.
  logic   last_b_reg, last_b_next;

  // Grant decision and next state. Everything is forced idle while reset is low.
  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    state_next  = state_reg;
    last_b_next = last_b_reg;
    if (rst_n) begin
      case (state_reg)
        ARB: begin
          if (a_req && b_req) begin
            a_gnt       = last_b_reg;
            b_gnt       = ~last_b_reg;
            last_b_next = ~last_b_reg;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
          if (b_gnt && b_lock) begin
            state_next = LOCK_B;
          end
        end
        LOCK_B: begin
          b_gnt = b_req;
          // Release on an unlocked access (which is still granted) or on an idle cycle.
          if (!b_req || !b_lock) begin
            state_next  = ARB;
            last_b_next = 1'b1;
          end
        end
        default: begin
          state_next = ARB;
        end
      endcase
    end
  end

  // Steer the winning port's fields onto the memory pins. The buses are zero when nothing is granted.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    if (a_gnt) begin
      mem_read   = ~a_we;
      mem_write  = a_we;
      mem_addr   = a_addr;
      mem_wdata  = a_wdata;
      mem_funct3 = a_funct3;
    end else if (b_gnt) begin
      mem_read   = ~b_we;
      mem_write  = b_we;
      mem_addr   = b_addr;
      mem_wdata  = b_wdata;
      mem_funct3 = b_funct3;
    end
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ARB;
      last_b_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      last_b_reg <= last_b_next;
    end
  end

  // Capture read data for the granted port. rdata holds until that port reads again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= mem_rdata;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and random checks of dmem_port_arbiter, with a behavioural data memory and reference model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata;
  logic [2:0]  a_funct3;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req, b_we, b_lock;
  logic [8:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_funct3;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  // dm stands in for the physical data memory. ref_mem is what memory should contain.
  logic [31:0] dm      [512];
  logic [31:0] ref_mem [512];

  // Reference model state.
  bit          m_b_owns;
  bit          m_a_turn;
  bit          m_rv [2];
  logic [31:0] m_rd [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_funct3(a_funct3),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_funct3(b_funct3), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3);
    case (f3)
      3'b000:  return {old[31:8], wd[7:0]};
      3'b001:  return {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  assign mem_rdata = load_ext(dm[mem_addr], mem_funct3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_a(input bit req, input bit we, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_funct3 = f3;
  endtask

  task automatic drive_b(input bit req, input bit we, input bit lock, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd; b_funct3 = f3;
  endtask

  task automatic model_reset();
    m_b_owns = 1'b0;
    m_a_turn = 1'b1;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    m_rd[0] = 32'h0; m_rd[1] = 32'h0;
  endtask

  // Run one clock cycle from posedge+1. Inputs must already be driven.
  task automatic step();
    int          w;        // 0 none, 1 A, 2 B
    bit          we;
    logic [8:0]  ad;
    logic [31:0] wd;
    logic [2:0]  f3;
    bit          seen_wr;
    logic [8:0]  seen_ad;
    logic [31:0] seen_wd;
    logic [2:0]  seen_f3;
    // Decide the expected winner from the arbitration rules.
    if (m_b_owns)           w = b_req ? 2 : 0;
    else if (a_req && b_req) w = m_a_turn ? 1 : 2;
    else if (a_req)         w = 1;
    else if (b_req)         w = 2;
    else                    w = 0;
    we = 1'b0; ad = '0; wd = '0; f3 = '0;
    if (w == 1) begin we = a_we; ad = a_addr; wd = a_wdata; f3 = a_funct3; end
    if (w == 2) begin we = b_we; ad = b_addr; wd = b_wdata; f3 = b_funct3; end
    @(negedge clk);
    check("a_gnt", 32'(a_gnt), 32'(w == 1));
    check("b_gnt", 32'(b_gnt), 32'(w == 2));
    check("mem_read", 32'(mem_read), 32'(w != 0 && !we));
    check("mem_write", 32'(mem_write), 32'(w != 0 && we));
    check("mem_addr", 32'(mem_addr), 32'(ad));
    check("mem_wdata", mem_wdata, wd);
    check("mem_funct3", 32'(mem_funct3), 32'(f3));
    seen_wr = mem_write; seen_ad = mem_addr; seen_wd = mem_wdata; seen_f3 = mem_funct3;
    @(posedge clk);
    #1;
    // The physical memory commits whatever the DUT presented at the edge.
    if (seen_wr) dm[seen_ad] = store_merge(dm[seen_ad], seen_wd, seen_f3);
    // Reference model update.
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    if (w != 0) begin
      if (we) ref_mem[ad] = store_merge(ref_mem[ad], wd, f3);
      else begin
        m_rv[w-1] = 1'b1;
        m_rd[w-1] = load_ext(ref_mem[ad], f3);
      end
    end
    if (!m_b_owns && a_req && b_req) m_a_turn = (w == 2);
    if (m_b_owns) begin
      if (!b_req || !b_lock) begin m_b_owns = 1'b0; m_a_turn = 1'b1; end
    end else if (w == 2 && b_lock) begin
      m_b_owns = 1'b1;
    end
    check("a_rvalid", 32'(a_rvalid), 32'(m_rv[0]));
    check("a_rdata", a_rdata, m_rd[0]);
    check("b_rvalid", 32'(b_rvalid), 32'(m_rv[1]));
    check("b_rdata", b_rdata, m_rd[1]);
    $display("step t=%0t w=%0d we=%0b addr=%0d f3=%0d a_rv=%0b a_rd=%h b_rv=%0b b_rd=%h",
             $time, w, we, ad, f3, a_rvalid, a_rdata, b_rvalid, b_rdata);
  endtask

  initial begin
    logic [2:0] rd_codes [5];
    logic [2:0] wr_codes [3];
    rd_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    wr_codes = '{3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 512; i++) begin
      dm[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    dm[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    dm[3] = 32'h00000080; ref_mem[3] = 32'h00000080;
    model_reset();

    // Reset holds every output idle, even with a request present.
    rst_n = 1'b0;
    drive_a(1, 0, 9'd5, 32'h0, 3'b010);
    drive_b(1, 0, 0, 9'd6, 32'h0, 3'b010);
    #12;
    check("rst_a_gnt", 32'(a_gnt), 32'h0);
    check("rst_b_gnt", 32'(b_gnt), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    drive_b(0, 0, 0, 9'd0, 32'h0, 3'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: Port A loads address 5. The response appears in the next cycle only.
    drive_a(1, 0, 9'd5, 32'h0, 3'b010);
    step();
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    step();

    // 2: Both ports request for four cycles. Grants alternate A,B,A,B.
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 0, 9'(10 + i), 32'h0, 3'b010);
      drive_b(1, 0, 0, 9'(20 + i), 32'h0, 3'b010);
      step();
    end
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    drive_b(0, 0, 0, 9'd0, 32'h0, 3'b0);

    // 3: Port B runs a locked store burst to addresses 0..2 while A waits.
    //    A is granted only after the burst ends.
    drive_b(1, 1, 1, 9'd0, 32'h11110000, 3'b010);
    step();
    drive_a(1, 0, 9'd5, 32'h0, 3'b010);
    drive_b(1, 1, 1, 9'd1, 32'h22221111, 3'b010);
    step();
    drive_b(1, 1, 0, 9'd2, 32'h33332222, 3'b010);
    step();
    drive_b(0, 0, 0, 9'd0, 32'h0, 3'b0);
    step();
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    check("burst_mem0", dm[0], 32'h11110000);
    check("burst_mem1", dm[1], 32'h22221111);
    check("burst_mem2", dm[2], 32'h33332222);

    // 4: A store to address 7 followed immediately by a load from address 7.
    drive_a(1, 1, 9'd7, 32'h12345678, 3'b010);
    step();
    drive_a(1, 0, 9'd7, 32'h0, 3'b010);
    step();
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);

    // 6: A signed byte load from address 3. 0x80 sign-extends to 0xFFFFFF80.
    drive_a(1, 0, 9'd3, 32'h0, 3'b000);
    step();
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    check("lb_rdata", a_rdata, 32'hFFFFFF80);

    // 5: Reset asserted mid-lock while a read is in flight.
    drive_b(1, 0, 1, 9'd5, 32'h0, 3'b010);
    step();
    drive_a(1, 0, 9'd3, 32'h0, 3'b010);
    drive_b(1, 0, 1, 9'd7, 32'h0, 3'b010);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_b_gnt", 32'(b_gnt), 32'h0);
    check("midrst_a_gnt", 32'(a_gnt), 32'h0);
    check("midrst_mem_read", 32'(mem_read), 32'h0);
    check("midrst_mem_addr", 32'(mem_addr), 32'h0);
    check("midrst_b_rvalid", 32'(b_rvalid), 32'h0);
    check("midrst_b_rdata", b_rdata, 32'h0);
    check("midrst_a_rdata", a_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("inrst_b_rvalid", 32'(b_rvalid), 32'h0);
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    drive_b(0, 0, 0, 9'd0, 32'h0, 3'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_a_rvalid", 32'(a_rvalid), 32'h0);
    check("postrst_b_rvalid", 32'(b_rvalid), 32'h0);
    // The FSM is back in ARB, so A alone is granted.
    drive_a(1, 0, 9'd7, 32'h0, 3'b010);
    step();
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);

    // Random traffic checked against the reference model.
    for (int i = 0; i < 300; i++) begin
      bit aw, bw;
      aw = ($urandom_range(0, 2) == 0);
      bw = ($urandom_range(0, 2) == 0);
      drive_a($urandom_range(0, 3) != 0, aw, 9'($urandom_range(0, 15)), $urandom,
              aw ? wr_codes[$urandom_range(0, 2)] : rd_codes[$urandom_range(0, 4)]);
      drive_b($urandom_range(0, 3) != 0, bw, $urandom_range(0, 2) != 0,
              9'($urandom_range(0, 15)), $urandom,
              bw ? wr_codes[$urandom_range(0, 2)] : rd_codes[$urandom_range(0, 4)]);
      step();
    end
    drive_a(0, 0, 9'd0, 32'h0, 3'b0);
    drive_b(0, 0, 0, 9'd0, 32'h0, 3'b0);
    step();
    for (int i = 0; i < 16; i++) check("final_mem", dm[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
